// File: rtl/mem_bus_pkg.sv
// Shared encodings for the icache/dcache memory bus arbiter.
package mem_bus_pkg;

  localparam int unsigned BEAT_BYTES     = 8;
  localparam int unsigned DEFAULT_ADDR_W = 64;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_IC_BURST = 2'd1;
  localparam logic [1:0] ST_DC_XFER  = 2'd2;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_e;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat counter for icache line fills: clear, increment, last-beat flag.
module burst_beat_counter #(
  parameter int unsigned BURST_BEATS = 8,
  localparam int unsigned BW = $clog2(BURST_BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [BW-1:0] beat,
  output logic          last
);

  logic [BW-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr) begin
      beat_d = '0;
    end else if (inc) begin
      beat_d = beat_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;
  assign last = (beat_q == BW'(BURST_BEATS - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the 64-bit memory bus: icache line bursts and dcache
// single beats. Define ARB_TIMEOUT_EN to abort transfers stalled on mem_ready.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned BURST_BEATS    = 8,
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [63:0]       ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [63:0]       dc_wdata,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic [63:0]       dc_rdata,
  output logic              dc_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [63:0]       mem_rdata,
  output logic              bus_err
);

  localparam int unsigned BW       = $clog2(BURST_BEATS);
  localparam int unsigned LINE_LSB = $clog2(BURST_BEATS * BEAT_BYTES);

  logic [1:0]    state_q, state_d;
  owner_e        last_grant_q, last_grant_d;
  logic          ic_rvalid_q, ic_rvalid_d, ic_done_q, ic_done_d;
  logic          dc_rvalid_q, dc_rvalid_d, dc_done_q, dc_done_d;
  logic [63:0]   ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic [BW-1:0] beat;
  logic          beat_last;
  logic          hs;

  burst_beat_counter #(.BURST_BEATS(BURST_BEATS)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .inc  ((state_q == ST_IC_BURST) && hs),
    .beat (beat),
    .last (beat_last)
  );

  assign mem_valid = (state_q != ST_IDLE);
  assign ic_gnt    = (state_q == ST_IC_BURST);
  assign dc_gnt    = (state_q == ST_DC_XFER);
  assign hs        = mem_valid && mem_ready;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == ST_IC_BURST) begin
      mem_addr = {ic_addr[ADDR_W-1:LINE_LSB], beat, 3'b000};
    end else if (state_q == ST_DC_XFER) begin
      mem_addr  = {dc_addr[ADDR_W-1:3], 3'b000};
      mem_we    = dc_we;
      mem_wdata = dc_wdata;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ic_rvalid_d  = 1'b0;
    ic_rdata_d   = ic_rdata_q;
    ic_done_d    = 1'b0;
    dc_rvalid_d  = 1'b0;
    dc_rdata_d   = dc_rdata_q;
    dc_done_d    = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      // The done cycle is a turnaround: the finished requester is still
      // holding its request, so nothing is granted until the next IDLE cycle.
      ST_IDLE: begin
        if (!ic_done_q && !dc_done_q) begin
          if (ic_req && (!dc_req || last_grant_q == OWNER_DC)) begin
            state_d      = ST_IC_BURST;
            last_grant_d = OWNER_IC;
          end else if (dc_req) begin
            state_d      = ST_DC_XFER;
            last_grant_d = OWNER_DC;
          end
        end
      end
      ST_IC_BURST: begin
        if (hs) begin
          ic_rvalid_d = 1'b1;
          ic_rdata_d  = mem_rdata;
          if (beat_last) begin
            state_d   = ST_IDLE;
            ic_done_d = 1'b1;
          end
        end
      end
      ST_DC_XFER: begin
        if (hs) begin
          state_d     = ST_IDLE;
          dc_done_d   = 1'b1;
          dc_rvalid_d = !dc_we;
          if (!dc_we) begin
            dc_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    wait_d = '0;
    if (mem_valid && !mem_ready) begin
      if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        bus_err_d = 1'b1;
        ic_done_d = (state_q == ST_IC_BURST);
        dc_done_d = (state_q == ST_DC_XFER);
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWNER_DC;
      ic_rvalid_q  <= 1'b0;
      ic_rdata_q   <= '0;
      ic_done_q    <= 1'b0;
      dc_rvalid_q  <= 1'b0;
      dc_rdata_q   <= '0;
      dc_done_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ic_rvalid_q  <= ic_rvalid_d;
      ic_rdata_q   <= ic_rdata_d;
      ic_done_q    <= ic_done_d;
      dc_rvalid_q  <= dc_rvalid_d;
      dc_rdata_q   <= dc_rdata_d;
      dc_done_q    <= dc_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign ic_rvalid = ic_rvalid_q;
  assign ic_rdata  = ic_rdata_q;
  assign ic_done   = ic_done_q;
  assign dc_rvalid = dc_rvalid_q;
  assign dc_rdata  = dc_rdata_q;
  assign dc_done   = dc_done_q;
  assign bus_err   = bus_err_q;

  logic unused_bits;
  assign unused_bits = ^{ic_addr[LINE_LSB-1:0], dc_addr[2:0]} ^ (TIMEOUT_CYCLES == 0);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (ARB_TIMEOUT_EN aware).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req = 1'b0;
  logic [63:0] ic_addr = '0;
  logic        ic_gnt, ic_rvalid, ic_done;
  logic [63:0] ic_rdata;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [63:0] dc_addr = '0;
  logic [63:0] dc_wdata = '0;
  logic        dc_gnt, dc_rvalid, dc_done;
  logic [63:0] dc_rdata;
  logic        mem_valid, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        bus_err;

  int tests  = 0;
  int failed = 0;

  mem_bus_arbiter #(
    .BURST_BEATS    (8),
    .ADDR_W         (64),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_gnt    (ic_gnt),
    .ic_rvalid (ic_rvalid),
    .ic_rdata  (ic_rdata),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_gnt    (dc_gnt),
    .dc_rvalid (dc_rvalid),
    .dc_rdata  (dc_rdata),
    .dc_done   (dc_done),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    tests++;
    if ({ic_gnt, dc_gnt, mem_valid, ic_rvalid, ic_done, dc_rvalid, dc_done, bus_err} !== 8'h00) begin
      failed++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {ic_gnt, dc_gnt, mem_valid, ic_rvalid, ic_done, dc_rvalid, dc_done, bus_err});
    end
    tests++;
    if (mem_addr !== 64'h0 || ic_rdata !== 64'h0 || dc_rdata !== 64'h0) begin
      failed++;
      $display("FAIL reset_data addr=%h ic_rdata=%h dc_rdata=%h want 0", mem_addr, ic_rdata, dc_rdata);
    end
    rst = 1'b0;
    step();
    tests++;
    if (mem_valid !== 1'b0) begin
      failed++;
      $display("FAIL idle_no_req mem_valid=%b want 0", mem_valid);
    end
  endtask

  task automatic test_ic_burst();
    ic_req = 1'b1; ic_addr = 64'h1038; mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      tests++;
      if (ic_gnt !== 1'b1 || mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h1000 + 64'(k) * 8) begin
        failed++;
        $display("FAIL burst_beat%0d gnt=%b valid=%b we=%b addr=%h want 1 1 0 %h",
                 k, ic_gnt, mem_valid, mem_we, mem_addr, 64'h1000 + 64'(k) * 8);
      end
      tests++;
      if (ic_rvalid !== (k > 0) || (k > 0 && ic_rdata !== 64'hA0 + 64'(k - 1)) || ic_done !== 1'b0) begin
        failed++;
        $display("FAIL burst_rdata%0d rvalid=%b rdata=%h done=%b", k, ic_rvalid, ic_rdata, ic_done);
      end
      mem_rdata = 64'hA0 + 64'(k);
    end
    step();
    tests++;
    if (ic_rvalid !== 1'b1 || ic_rdata !== 64'hA7 || ic_done !== 1'b1 || ic_gnt !== 1'b0 || mem_valid !== 1'b0) begin
      failed++;
      $display("FAIL burst_last rvalid=%b rdata=%h done=%b gnt=%b valid=%b want 1 a7 1 0 0",
               ic_rvalid, ic_rdata, ic_done, ic_gnt, mem_valid);
    end
    ic_req = 1'b0;
    step();
    tests++;
    if (ic_done !== 1'b0 || ic_rvalid !== 1'b0 || ic_gnt !== 1'b0) begin
      failed++;
      $display("FAIL burst_after done=%b rvalid=%b gnt=%b want 0 0 0", ic_done, ic_rvalid, ic_gnt);
    end
  endtask

  task automatic test_dc_read_wait();
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h2004; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      tests++;
      if (dc_gnt !== 1'b1 || mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h2000 || dc_done !== 1'b0) begin
        failed++;
        $display("FAIL dc_wait%0d gnt=%b valid=%b we=%b addr=%h done=%b want 1 1 0 2000 0",
                 k, dc_gnt, mem_valid, mem_we, mem_addr, dc_done);
      end
      if (k == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 64'hDEADBEEF;
      end
    end
    step();
    tests++;
    if (dc_rvalid !== 1'b1 || dc_rdata !== 64'hDEADBEEF || dc_done !== 1'b1 || dc_gnt !== 1'b0 || mem_valid !== 1'b0) begin
      failed++;
      $display("FAIL dc_read rvalid=%b rdata=%h done=%b gnt=%b valid=%b want 1 deadbeef 1 0 0",
               dc_rvalid, dc_rdata, dc_done, dc_gnt, mem_valid);
    end
    dc_req = 1'b0;
    step();
    tests++;
    if (dc_done !== 1'b0 || dc_rvalid !== 1'b0) begin
      failed++;
      $display("FAIL dc_done_pulse done=%b rvalid=%b want 0 0", dc_done, dc_rvalid);
    end
  endtask

  task automatic test_tie_round_robin();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    ic_req = 1'b1; ic_addr = 64'h4000; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h5000; mem_ready = 1'b1;
    step();
    tests++;
    if (ic_gnt !== 1'b1 || dc_gnt !== 1'b0) begin
      failed++;
      $display("FAIL tie1_ic_first ic_gnt=%b dc_gnt=%b want 1 0", ic_gnt, dc_gnt);
    end
    for (int n = 0; n < 20 && !ic_done; n++) begin
      step();
      if (dc_gnt !== 1'b0) begin
        tests++;
        failed++;
        $display("FAIL tie1_dc_waits dc_gnt=%b want 0", dc_gnt);
      end
    end
    tests++;
    if (ic_done !== 1'b1) begin
      failed++;
      $display("FAIL tie1_ic_done timeout ic_done=%b want 1", ic_done);
    end
    ic_req = 1'b0;
    step();
    tests++;
    if (dc_gnt !== 1'b0 || mem_valid !== 1'b0) begin
      failed++;
      $display("FAIL tie1_turnaround dc_gnt=%b valid=%b want 0 0", dc_gnt, mem_valid);
    end
    step();
    tests++;
    if (dc_gnt !== 1'b1 || mem_addr !== 64'h5000) begin
      failed++;
      $display("FAIL tie1_dc_second dc_gnt=%b addr=%h want 1 5000", dc_gnt, mem_addr);
    end
    step();
    dc_req = 1'b0;
    step();
    // icache alone so the most recent grant is icache
    ic_req = 1'b1;
    for (int n = 0; n < 20 && !ic_done; n++) step();
    ic_req = 1'b0;
    step();
    ic_req = 1'b1; dc_req = 1'b1;
    step();
    tests++;
    if (dc_gnt !== 1'b1 || ic_gnt !== 1'b0) begin
      failed++;
      $display("FAIL tie2_dc_first dc_gnt=%b ic_gnt=%b want 1 0", dc_gnt, ic_gnt);
    end
    step();
    dc_req = 1'b0;
    step();
    step();
    tests++;
    if (ic_gnt !== 1'b1 || mem_addr !== 64'h4000) begin
      failed++;
      $display("FAIL tie2_ic_second ic_gnt=%b addr=%h want 1 4000", ic_gnt, mem_addr);
    end
    for (int n = 0; n < 20 && !ic_done; n++) step();
    ic_req = 1'b0;
    step();
  endtask

  task automatic test_dc_write_during_burst();
    ic_req = 1'b1; ic_addr = 64'h6000; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 64'h3000; dc_wdata = 64'h55;
    for (int n = 0; n < 20 && !ic_done; n++) begin
      step();
      if (dc_gnt !== 1'b0 || (mem_valid && mem_we !== 1'b0)) begin
        tests++;
        failed++;
        $display("FAIL wr_wait dc_gnt=%b mem_we=%b want 0 0", dc_gnt, mem_we);
      end
    end
    tests++;
    if (ic_done !== 1'b1) begin
      failed++;
      $display("FAIL wr_burst_done timeout ic_done=%b want 1", ic_done);
    end
    ic_req = 1'b0;
    step();
    step();
    tests++;
    if (dc_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h3000 || mem_wdata !== 64'h55) begin
      failed++;
      $display("FAIL wr_beat gnt=%b we=%b addr=%h wdata=%h want 1 1 3000 55", dc_gnt, mem_we, mem_addr, mem_wdata);
    end
    step();
    tests++;
    if (dc_done !== 1'b1 || dc_rvalid !== 1'b0) begin
      failed++;
      $display("FAIL wr_done done=%b rvalid=%b want 1 0", dc_done, dc_rvalid);
    end
    dc_req = 1'b0; dc_we = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    ic_req = 1'b1; ic_addr = 64'h7000; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    tests++;
    if (mem_addr !== 64'h7018) begin
      failed++;
      $display("FAIL rst_beat3 addr=%h want 7018", mem_addr);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({ic_gnt, mem_valid, ic_rvalid, ic_done} !== 4'b0000 || mem_addr !== 64'h0) begin
      failed++;
      $display("FAIL rst_async ctrl=%b addr=%h want 0000 0", {ic_gnt, mem_valid, ic_rvalid, ic_done}, mem_addr);
    end
    step();
    rst = 1'b0;
    step();
    tests++;
    if (ic_gnt !== 1'b1 || mem_addr !== 64'h7000 || ic_done !== 1'b0) begin
      failed++;
      $display("FAIL rst_restart gnt=%b addr=%h done=%b want 1 7000 0", ic_gnt, mem_addr, ic_done);
    end
    for (int n = 0; n < 20 && !ic_done; n++) step();
    ic_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    ic_req = 1'b1; ic_addr = 64'h8000; mem_ready = 1'b0;
    step();
    for (int k = 1; k < 16; k++) begin
      step();
      if (mem_valid !== 1'b1 || bus_err !== 1'b0) begin
        tests++;
        failed++;
        $display("FAIL stall%0d valid=%b bus_err=%b want 1 0", k, mem_valid, bus_err);
      end
    end
    step();
`ifdef ARB_TIMEOUT_EN
    tests++;
    if (bus_err !== 1'b1 || ic_done !== 1'b1 || ic_rvalid !== 1'b0 || ic_gnt !== 1'b0 || mem_valid !== 1'b0) begin
      failed++;
      $display("FAIL timeout_abort err=%b done=%b rvalid=%b gnt=%b valid=%b want 1 1 0 0 0",
               bus_err, ic_done, ic_rvalid, ic_gnt, mem_valid);
    end
    ic_req = 1'b0; mem_ready = 1'b1;
    step();
    tests++;
    if (bus_err !== 1'b0 || ic_done !== 1'b0) begin
      failed++;
      $display("FAIL timeout_pulse err=%b done=%b want 0 0", bus_err, ic_done);
    end
`else
    tests++;
    if (bus_err !== 1'b0 || mem_valid !== 1'b1 || ic_done !== 1'b0 || mem_addr !== 64'h8000) begin
      failed++;
      $display("FAIL no_timeout err=%b valid=%b done=%b addr=%h want 0 1 0 8000", bus_err, mem_valid, ic_done, mem_addr);
    end
    mem_ready = 1'b1;
    for (int n = 0; n < 20 && !ic_done; n++) step();
    tests++;
    if (ic_done !== 1'b1 || bus_err !== 1'b0) begin
      failed++;
      $display("FAIL stall_release done=%b err=%b want 1 0", ic_done, bus_err);
    end
    ic_req = 1'b0;
    step();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ic_burst();
    test_dc_read_wait();
    test_tie_round_robin();
    test_dc_write_during_burst();
    test_reset_mid_burst();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single 64-bit memory bus between the instruction-cache refill path and the data-cache path. Sequences an icache line fill as a fixed-length burst of 64-bit beats, and a dcache access as a single-beat read or write. Uses round-robin arbitration and returns read data to the owning requester. Sits between both caches and the memory bus.

Parameters:
BURST_BEATS, 8, beats per icache line fill (8 x 8 B = 64 B line); power of two, >= 2
ADDR_W, 64, address width
TIMEOUT_CYCLES, 256, cycles waiting for mem_ready before abort (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ic_req  in  1  icache refill request; held until ic_done
ic_addr  in  ADDR_W  refill address; low log2(BURST_BEATS*8) bits ignored
ic_gnt  out  1  icache owns bus
ic_rvalid  out  1  refill beat valid
ic_rdata  out  64  refill beat data
ic_done  out  1  one-cycle pulse with last beat
dc_req  in  1  dcache request; held until dc_done
dc_we  in  1  1 = write
dc_addr  in  ADDR_W  8-byte aligned address
dc_wdata  in  64  write data
dc_gnt  out  1  dcache owns bus
dc_rvalid  out  1  read data valid (reads only)
dc_rdata  out  64  read data
dc_done  out  1  one-cycle completion pulse
mem_valid  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  ADDR_W  beat address
mem_wdata  out  64  write data
mem_ready  in  1  beat accepted/completed this cycle
mem_rdata  in  64  read data, valid with mem_ready
bus_err  out  1  timeout abort pulse; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All outputs and state reset to 0. FSM resets to IDLE, beat counter to 0, and last_grant to DC, so the first tie goes to icache.
- FSM states: IDLE, IC_BURST, DC_XFER.
- IDLE: evaluate requests each cycle. If only one request is active, grant it. If both are active, grant the requester that was not last_grant. The grant is registered: ic_gnt or dc_gnt and mem_valid rise on the cycle after the request is sampled. last_grant updates at grant time.
- IC_BURST:
  - mem_addr = {ic_addr[ADDR_W-1:log2(BURST_BEATS*8)], beat, 3'b000}; mem_we = 0.
  - Beat k completes on mem_valid && mem_ready. The counter then increments; mem_valid stays asserted for the next beat with no gap.
  - ic_rvalid/ic_rdata are registered: asserted one cycle after each handshake with the captured mem_rdata.
  - After the beat BURST_BEATS-1 handshake: mem_valid drops, ic_gnt drops, the state returns to IDLE, and ic_done pulses together with the final ic_rvalid.
- DC_XFER:
  - One beat: mem_addr = dc_addr with [2:0] forced to 0; mem_we = dc_we; mem_wdata = dc_wdata.
  - On handshake: dc_done pulses next cycle. For reads, dc_rvalid pulses with captured dc_rdata. Return to IDLE.
- Turnaround: at least one IDLE cycle between consecutive grants, so no back-to-back ownership change in one cycle.
- mem_valid and the address/write fields stay stable while mem_ready is low.
- Request deasserted mid-transfer: ignored; the transfer runs to completion. A request asserted during the other's transfer waits.
- A new request from the same requester arriving in the done cycle is not granted until IDLE samples it.
- Reset mid-burst: immediate abort to IDLE, outputs 0, no done pulse.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a wait counter counts cycles with mem_valid && !mem_ready and clears on each handshake. On reaching TIMEOUT_CYCLES, the current transfer aborts: mem_valid drops and the state goes to IDLE. bus_err pulses for one cycle together with the owner's done pulse, with no rvalid for the aborted beat.
- Undefined: no counter; waits indefinitely; bus_err tied 0.

Decomposition:
- Shared package mem_bus_pkg: FSM state encodings, BEAT_BYTES=8, default ADDR_W, owner encoding (OWNER_IC/OWNER_DC).
- One sub-module, burst_beat_counter: beat counter with load/increment/last-beat flag, parameterised by BURST_BEATS.

Test Plan:
1. ic_req, ic_addr=0x1038, mem_ready always 1 -> mem_addr 0x1000,0x1008..0x1038 on consecutive cycles; 8 ic_rvalid; ic_done with 8th; ic_gnt low after.
2. dc_req read at 0x2004, mem_ready after 3 wait cycles, mem_rdata=0xDEADBEEF -> mem_addr held 0x2000 for 4 cycles; dc_rvalid with 0xDEADBEEF, dc_done one pulse.
3. ic_req and dc_req asserted the same cycle after reset -> icache granted first; dcache granted after ic_done plus one IDLE cycle. Repeat the tie -> dcache first.
4. dc write 0x3000 data 0x55 while icache burst is mid-way -> dcache waits; write beat mem_we=1 with wdata 0x55 after the burst; no dc_rvalid.
5. rst asserted at beat 3 of an icache burst -> all outputs 0 asynchronously; after release, ic_req still high -> a fresh burst starts from beat 0.
6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ready held 0 -> bus_err and ic_done pulse at wait cycle 16; return to IDLE; no ic_rvalid.
